echo_capture: RTL
=================

ECHO_CAPTURE -- requirements
Module: echo_capture

Interface
REQ-001 Parameter DECIM, default 4, meaning: valid input samples folded into one stored bin (range 1..256).
REQ-002 Parameter BLANK, default 16, meaning: valid samples discarded after ping start to mask transmit ringing (range 0..65535).
REQ-003 Parameter BINS, default 2048, meaning: bins written per ping; equals the 2k x 8 echo buffer depth.
REQ-004 clk  input  1  system clock; all logic rising-edge.
REQ-005 resetn  input  1  asynchronous active-low reset.
REQ-006 ping_start  input  1  single-cycle pulse marking transducer fire.
REQ-007 sample_valid  input  1  qualifies sample for one cycle.
REQ-008 sample  input  12  unsigned rectified echo amplitude.
REQ-009 wr_ce  output  1  buffer write-port clock enable (drives cea).
REQ-010 wr_addr  output  11  buffer write address (drives ada).
REQ-011 wr_data  output  8  buffer write data (drives din).
REQ-012 busy  output  1  high in BLANK, CAPTURE or DONE states.
REQ-013 frame_done  output  1  single-cycle pulse after last bin written.
REQ-014 retrig_err  output  1  sticky flag: ping_start seen while busy.

Function
REQ-015 The block SHALL implement states IDLE, BLANK, CAPTURE, DONE.
REQ-016 IDLE -> BLANK on ping_start; blank counter and bin counter cleared to 0, peak register cleared to 0.
REQ-017 If BLANK=0, IDLE SHALL go directly to CAPTURE on ping_start.
REQ-018 BLANK: each sample_valid increments blank counter; on the BLANK-th valid sample -> CAPTURE; that sample SHALL be discarded.
REQ-019 CAPTURE: each sample_valid updates peak = max(peak, sample) and increments decimation counter.
REQ-020 On the DECIM-th valid sample of a bin, the next cycle SHALL assert wr_ce for exactly one cycle with wr_addr = bin index and wr_data = final_peak[11:4], final_peak including that sample.
REQ-021 Peak and decimation counter SHALL restart from 0 on the same edge the bin completes, so a sample_valid on the wr_ce cycle belongs to the next bin (no sample lost at back-to-back valid).
REQ-022 Bin index SHALL increment after each write; after the write of bin BINS-1 the state SHALL be DONE.
REQ-023 DONE SHALL last exactly one cycle, assert frame_done, then return to IDLE; samples in DONE and IDLE SHALL be ignored.
REQ-024 wr_ce SHALL be 0 in IDLE, BLANK and DONE except for the REQ-020 write cycle; wr_addr and wr_data SHALL hold last written values when wr_ce=0.
REQ-025 ping_start while busy SHALL NOT restart the sweep and SHALL set retrig_err.
REQ-026 retrig_err SHALL clear on the next ping_start accepted in IDLE.
REQ-027 Bin index SHALL never wrap within a sweep; no write to addresses >= BINS.
REQ-028 Latency sample_valid (bin-completing) to wr_ce: exactly 1 cycle.

Reset
REQ-029 Asserting resetn low SHALL immediately force state IDLE, wr_ce=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, retrig_err=0, all counters and peak 0.
REQ-030 Reset mid-sweep SHALL abort with no further writes; after release the block SHALL wait for a new ping_start.

Verification
REQ-031 DECIM=4, BLANK=16: ping, 16 valids of 0xFFF, then valids 0x100,0x7F0,0x010,0x200 -> single wr_ce, wr_addr=0, wr_data=0x7F.
REQ-032 Continuous sample_valid every cycle, full sweep -> exactly 2048 wr_ce pulses, addresses 0..2047 in order, one frame_done after address 2047 write, busy low next cycle.
REQ-033 ping_start pulsed during CAPTURE at bin 100 -> sweep continues to 2047 uninterrupted, retrig_err=1; next ping in IDLE -> retrig_err=0.
REQ-034 resetn low during bin 500 -> wr_ce=0 same cycle, all outputs 0; no writes until new ping.
REQ-035 BLANK=0, DECIM=1, valids 0xABC then 0x012 -> wr_data 0xAB at addr 0, 0x01 at addr 1, each 1 cycle after its valid.
REQ-036 sample_valid gapped (1 in 3 cycles) -> bin contents identical to gap-free run with same sample sequence.

Source files
------------

// File: rtl/echo_capture.sv
// Echo sweep capture: blanks transmit ringing, then peak-decimates rectified samples
// into bins and streams one byte per bin to the write port of the 2k x 8 echo buffer.
module echo_capture #(
    parameter int unsigned DECIM = 4,
    parameter int unsigned BLANK = 16,
    parameter int unsigned BINS  = 2048
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ping_start,
    input  logic        sample_valid,
    input  logic [11:0] sample,
    output logic        wr_ce,
    output logic [10:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        frame_done,
    output logic        retrig_err
);

    localparam logic [7:0]  DecimLast = 8'(DECIM - 1);
    localparam logic [15:0] BlankLast = 16'((BLANK == 0) ? 0 : BLANK - 1);
    localparam logic [11:0] BinsEnd   = 12'(BINS);

    typedef enum logic [1:0] {
        StIdle,
        StBlank,
        StCapture,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] blank_cnt_q, blank_cnt_d;
    logic [7:0]  decim_cnt_q, decim_cnt_d;
    logic [11:0] peak_q, peak_d;
    logic [11:0] bin_q, bin_d;
    logic        wr_ce_q, wr_ce_d;
    logic [10:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        retrig_q, retrig_d;

    logic        sweep_end;
    logic        bin_last_sample;
    logic [11:0] peak_max;

    // bin_q reaches BINS only after the final bin's write has been issued.
    assign sweep_end       = (bin_q == BinsEnd);
    assign bin_last_sample = (decim_cnt_q == DecimLast);
    assign peak_max        = (sample > peak_q) ? sample : peak_q;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (ping_start) begin
                    state_d = (BLANK == 0) ? StCapture : StBlank;
                end
            end
            StBlank: begin
                if (sample_valid && (blank_cnt_q == BlankLast)) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                if (sweep_end) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy       = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            StIdle:    busy = 1'b0;
            StBlank:   busy = 1'b1;
            StCapture: busy = 1'b1;
            StDone: begin
                busy       = 1'b1;
                frame_done = 1'b1;
            end
            default:   busy = 1'b0;
        endcase
    end

    // Datapath next-state: counters, peak tracker and buffer write port
    always_comb begin
        blank_cnt_d = blank_cnt_q;
        decim_cnt_d = decim_cnt_q;
        peak_d      = peak_q;
        bin_d       = bin_q;
        wr_ce_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        retrig_d    = retrig_q;

        if (ping_start) begin
            retrig_d = (state_q != StIdle);
        end

        unique case (state_q)
            StIdle: begin
                if (ping_start) begin
                    blank_cnt_d = '0;
                    decim_cnt_d = '0;
                    peak_d      = '0;
                    bin_d       = '0;
                end
            end
            StBlank: begin
                if (sample_valid) begin
                    blank_cnt_d = blank_cnt_q + 16'd1;
                end
            end
            StCapture: begin
                if (sample_valid && !sweep_end) begin
                    if (bin_last_sample) begin
                        // Restart the bin on this edge so a valid on the write cycle is kept.
                        wr_ce_d     = 1'b1;
                        wr_addr_d   = bin_q[10:0];
                        wr_data_d   = peak_max[11:4];
                        peak_d      = '0;
                        decim_cnt_d = '0;
                        bin_d       = bin_q + 12'd1;
                    end else begin
                        peak_d      = peak_max;
                        decim_cnt_d = decim_cnt_q + 8'd1;
                    end
                end
            end
            StDone: begin
                blank_cnt_d = blank_cnt_q;
            end
            default: begin
                blank_cnt_d = blank_cnt_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            blank_cnt_q <= '0;
            decim_cnt_q <= '0;
            peak_q      <= '0;
            bin_q       <= '0;
            wr_ce_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            retrig_q    <= 1'b0;
        end else begin
            blank_cnt_q <= blank_cnt_d;
            decim_cnt_q <= decim_cnt_d;
            peak_q      <= peak_d;
            bin_q       <= bin_d;
            wr_ce_q     <= wr_ce_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            retrig_q    <= retrig_d;
        end
    end

    assign wr_ce      = wr_ce_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign retrig_err = retrig_q;

endmodule
